row_scanner: RTL and testbench
==============================

ROW_SCANNER -- requirements
Module: row_scanner

Interface
REQ-001 Parameter H_VIEW, default 640: visible pixels per line along the wall-scan axis (hpos).
REQ-002 Parameter SIZE_BITS, default 11: width of i_size.
REQ-003 Parameter FW, default 16: width of the fixed-point texture accumulator and its inputs.
REQ-004 Parameter TEX_BITS, default 6: texel coordinate width (texture is 2^TEX_BITS square).
REQ-005 Parameter TEXV_SHIFT, default 3: accumulator bit index of texv LSB.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 hmax  in  1  high for the last cycle of each line (hpos==799); line-boundary strobe.
REQ-009 hpos  in  10  current horizontal pixel position.
REQ-010 i_valid  in  1  tracer result valid, sampled at hmax.
REQ-011 i_side, i_size[SIZE_BITS], i_texu[TEX_BITS], i_texa[FW], i_texVinit[FW]  in  tracer results, sampled at hmax.
REQ-012 o_wall_en  out  1  high while the current pixel is wall.
REQ-013 o_side  out  1, o_texu  out  TEX_BITS: latched per-line values.
REQ-014 o_texv  out  TEX_BITS: current texel row.

Function
REQ-015 FSM states IDLE, BEFORE, WALL, AFTER; o_wall_en SHALL equal (state==WALL), registered.
REQ-016 On hmax: latch i_side, i_texu, i_texa; load texV <= i_texVinit; compute half = i_size>>1.
REQ-017 Span: start = (half>=H_VIEW/2) ? 0 : H_VIEW/2-half; end = (half>=H_VIEW/2) ? H_VIEW : H_VIEW/2+half; both registered at hmax.
REQ-018 On hmax: i_valid==0 or i_size<2 -> IDLE; else start==0 -> WALL; else BEFORE.
REQ-019 BEFORE -> WALL on the cycle hpos==start-1; WALL -> AFTER on the cycle hpos==end-1; AFTER and IDLE hold until hmax.
REQ-020 Net effect: o_wall_en high for exactly hpos in [start,end), end-start cycles per line.
REQ-021 texV SHALL add latched texa (mod 2^FW) every cycle state==WALL; otherwise hold.
REQ-022 o_texv = texV[TEX_BITS+TEXV_SHIFT-1:TEXV_SHIFT] (subject to REQ-027).
REQ-023 hmax during WALL: hmax takes priority; new line latched, no extra increment.
REQ-024 Latency: inputs sampled at hmax affect outputs from the next cycle (hpos==0).

Reset
REQ-025 Reset SHALL win over hmax; state IDLE, texV 0, o_wall_en 0, o_side 0, o_texu 0, o_texv 0, start/end 0.
REQ-026 Reset mid-line SHALL suppress wall output until the next hmax after reset deasserts.

Configuration
REQ-027 Macro ROW_SCANNER_CLAMP_EN: defined -> if texV >= 2^(TEX_BITS+TEXV_SHIFT) o_texv SHALL be all ones and texV SHALL stop incrementing; undefined -> texV wraps and o_texv takes raw bits (texel wrap).

Verification
REQ-028 size=200, valid=1, hmax -> o_wall_en high hpos 220..419 only (200 cycles).
REQ-029 size=700 -> o_wall_en high from hpos 0 to 639 inclusive, low 640..799.
REQ-030 texVinit=0, texa=0x0004, size=200 -> o_texv 0 at hpos 220-221, 1 at 222-223, 2 at 224.
REQ-031 texVinit=0x01F0, texa=0x0008 -> o_texv 62,63, then 63 with ROW_SCANNER_CLAMP_EN, 0 without.
REQ-032 valid=0 at hmax (any size) -> o_wall_en low whole line; next valid line renders normally.
REQ-033 reset asserted at hpos 300 during wall -> o_wall_en 0 next cycle and all outputs 0 until next hmax.

Source files
------------

// File: rtl/row_scanner.sv
// -----------------------------------------------------------------------------
// row_scanner
//
// Purpose:
//   Per-line wall renderer for a ray-cast display. At the end of each line
//   (hmax) the tracer result for the next line is latched. During the next
//   line the module raises o_wall_en for the centred span of visible pixels
//   occupied by the wall. It also steps a fixed-point vertical texture
//   coordinate once per wall pixel.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   synchronous, active-high reset
//   hmax         in   last cycle of a line; latches the tracer inputs
//   hpos[9:0]    in   current horizontal pixel position
//   i_valid      in   tracer result valid (sampled at hmax)
//   i_side       in   wall side flag (sampled at hmax)
//   i_size       in   wall height in pixels (sampled at hmax)
//   i_texu       in   texel column (sampled at hmax)
//   i_texa       in   per-pixel texture V step (sampled at hmax)
//   i_texVinit   in   starting texture V accumulator (sampled at hmax)
//   o_wall_en    out  high while the current pixel is wall
//   o_side       out  latched side flag
//   o_texu       out  latched texel column
//   o_texv       out  current texel row
//
// Configuration:
//   ROW_SCANNER_CLAMP_EN  when defined, the texture V accumulator saturates
//                         once it leaves the texture, and o_texv sticks at
//                         all ones. When undefined, the accumulator wraps and
//                         o_texv repeats the texture.
// -----------------------------------------------------------------------------
module row_scanner #(
    parameter int H_VIEW     = 640,
    parameter int SIZE_BITS  = 11,
    parameter int FW         = 16,
    parameter int TEX_BITS   = 6,
    parameter int TEXV_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hmax,
    input  logic [9:0]           hpos,
    input  logic                 i_valid,
    input  logic                 i_side,
    input  logic [SIZE_BITS-1:0] i_size,
    input  logic [TEX_BITS-1:0]  i_texu,
    input  logic [FW-1:0]        i_texa,
    input  logic [FW-1:0]        i_texVinit,
    output logic                 o_wall_en,
    output logic                 o_side,
    output logic [TEX_BITS-1:0]  o_texu,
    output logic [TEX_BITS-1:0]  o_texv
);

    localparam int unsigned HALF_VIEW = H_VIEW / 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BEFORE = 2'd1,
        WALL   = 2'd2,
        AFTER  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [9:0]            start_q, start_d;
    logic [9:0]            end_q,   end_d;
    logic [FW-1:0]         texv_q,  texv_d;
    logic [FW-1:0]         texa_q,  texa_d;
    logic                  side_q,  side_d;
    logic [TEX_BITS-1:0]   texu_q,  texu_d;

    logic [SIZE_BITS-1:0]  half;
    logic [9:0]            start_calc;
    logic [9:0]            end_calc;
    logic                  texv_sat;

`ifdef ROW_SCANNER_CLAMP_EN
    localparam logic [FW-1:0] TEXV_LIMIT = FW'(1) << (TEX_BITS + TEXV_SHIFT);
    // Once the accumulator has walked off the bottom of the texture, freeze it.
    assign texv_sat = (texv_q >= TEXV_LIMIT);
`else
    assign texv_sat = 1'b0;
`endif

    // Centred wall span for the line being latched. A wall at least as tall
    // as the view covers the whole visible line.
    always_comb begin
        half = i_size >> 1;
        if (32'(half) >= HALF_VIEW) begin
            start_calc = '0;
            end_calc   = 10'(H_VIEW);
        end else begin
            start_calc = 10'(HALF_VIEW - 32'(half));
            end_calc   = 10'(HALF_VIEW + 32'(half));
        end
    end

    // Next-state logic. hmax has priority over every in-line transition, so a
    // line boundary always starts a fresh line, and WALL adds no step there.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        end_d   = end_q;
        texv_d  = texv_q;
        texa_d  = texa_q;
        side_d  = side_q;
        texu_d  = texu_q;

        if (hmax) begin
            side_d  = i_side;
            texu_d  = i_texu;
            texa_d  = i_texa;
            texv_d  = i_texVinit;
            start_d = start_calc;
            end_d   = end_calc;
            if (!i_valid || (i_size < SIZE_BITS'(2))) begin
                state_d = IDLE;
            end else if (start_calc == 10'd0) begin
                state_d = WALL;
            end else begin
                state_d = BEFORE;
            end
        end else begin
            unique case (state_q)
                // Transitions fire one pixel early, so the registered state
                // lines up with hpos == start and hpos == end.
                BEFORE: begin
                    if (hpos == start_q - 10'd1) begin
                        state_d = WALL;
                    end
                end
                WALL: begin
                    if (!texv_sat) begin
                        texv_d = texv_q + texa_q;
                    end
                    if (hpos == end_q - 10'd1) begin
                        state_d = AFTER;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= '0;
            end_q   <= '0;
            texv_q  <= '0;
            texa_q  <= '0;
            side_q  <= 1'b0;
            texu_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            end_q   <= end_d;
            texv_q  <= texv_d;
            texa_q  <= texa_d;
            side_q  <= side_d;
            texu_q  <= texu_d;
        end
    end

    assign o_wall_en = (state_q == WALL);
    assign o_side    = side_q;
    assign o_texu    = texu_q;
    assign o_texv    = texv_sat ? '1 : texv_q[TEX_BITS+TEXV_SHIFT-1:TEXV_SHIFT];

endmodule

// File: tb/tb_row_scanner.sv
module tb_row_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        hmax;
    logic [9:0]  hpos;
    logic        i_valid;
    logic        i_side;
    logic [10:0] i_size;
    logic [5:0]  i_texu;
    logic [15:0] i_texa;
    logic [15:0] i_texVinit;
    logic        o_wall_en;
    logic        o_side;
    logic [5:0]  o_texu;
    logic [5:0]  o_texv;

    int n_checks = 0;
    int n_pass   = 0;

    bit         wall_a [800];
    logic [5:0] texv_a [800];
    logic       side0;
    logic [5:0] texu0;

    row_scanner dut (
        .clk        (clk),
        .reset      (reset),
        .hmax       (hmax),
        .hpos       (hpos),
        .i_valid    (i_valid),
        .i_side     (i_side),
        .i_size     (i_size),
        .i_texu     (i_texu),
        .i_texa     (i_texa),
        .i_texVinit (i_texVinit),
        .o_wall_en  (o_wall_en),
        .o_side     (o_side),
        .o_texu     (o_texu),
        .o_texv     (o_texv)
    );

    always #5 clk = ~clk;

    // One pixel clock: advance the raster, then sample outputs 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        hpos = (hpos == 10'd799) ? 10'd0 : hpos + 10'd1;
        hmax = (hpos == 10'd799);
    endtask

    task automatic goto_hmax();
        while (hpos != 10'd799) tick();
    endtask

    // Called with hpos==799 and the inputs set; records the following line.
    task automatic capture_line();
        tick();
        side0 = o_side;
        texu0 = o_texu;
        for (int i = 0; i < 800; i++) begin
            wall_a[i] = o_wall_en;
            texv_a[i] = o_texv;
            if (i < 799) tick();
        end
    endtask

    task automatic set_in(input logic v, input logic s, input int sz,
                          input int tu, input int ta, input int ti);
        i_valid    = v;
        i_side     = s;
        i_size     = 11'(sz);
        i_texu     = 6'(tu);
        i_texa     = 16'(ta);
        i_texVinit = 16'(ti);
    endtask

    task automatic line_stats(output int first, output int last, output int count);
        first = -1; last = -1; count = 0;
        for (int i = 0; i < 800; i++) begin
            if (wall_a[i]) begin
                if (first < 0) first = i;
                last = i;
                count++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b1, 1'b1, 200, 9, 4, 100);
        hmax = 1'b1;
        repeat (3) tick();
        n_checks++; if (o_wall_en !== 1'b0) $display("FAIL reset_wall got %0b want 0", o_wall_en); else n_pass++;
        n_checks++; if (o_side !== 1'b0) $display("FAIL reset_side got %0b want 0", o_side); else n_pass++;
        n_checks++; if (o_texu !== 6'd0) $display("FAIL reset_texu got %0d want 0", o_texu); else n_pass++;
        n_checks++; if (o_texv !== 6'd0) $display("FAIL reset_texv got %0d want 0", o_texv); else n_pass++;
        reset = 1'b0;
        goto_hmax();
    endtask

    task automatic test_span(input int sz, input int ef, input int el, input int ec, input string nm);
        int f, l, c;
        set_in(1'b1, 1'b1, sz, 5, 0, 0);
        capture_line();
        line_stats(f, l, c);
        n_checks++; if (f != ef) $display("FAIL %s_first got %0d want %0d", nm, f, ef); else n_pass++;
        n_checks++; if (l != el) $display("FAIL %s_last got %0d want %0d", nm, l, el); else n_pass++;
        n_checks++; if (c != ec) $display("FAIL %s_count got %0d want %0d", nm, c, ec); else n_pass++;
    endtask

    task automatic test_latch();
        set_in(1'b1, 1'b1, 200, 37, 0, 0);
        capture_line();
        n_checks++; if (side0 !== 1'b1) $display("FAIL latch_side got %0b want 1", side0); else n_pass++;
        n_checks++; if (texu0 !== 6'd37) $display("FAIL latch_texu got %0d want 37", texu0); else n_pass++;
    endtask

    task automatic test_texv_step();
        logic [5:0] exp [5] = '{6'd0, 6'd0, 6'd1, 6'd1, 6'd2};
        set_in(1'b1, 1'b0, 200, 0, 16'h0004, 16'h0000);
        capture_line();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (texv_a[220+k] !== exp[k])
                $display("FAIL texv_step@%0d got %0d want %0d", 220+k, texv_a[220+k], exp[k]);
            else n_pass++;
        end
    endtask

    task automatic test_texv_edge();
        logic [5:0] e222;
`ifdef ROW_SCANNER_CLAMP_EN
        e222 = 6'd63;
`else
        e222 = 6'd0;
`endif
        set_in(1'b1, 1'b0, 200, 0, 16'h0008, 16'h01F0);
        capture_line();
        n_checks++; if (texv_a[220] !== 6'd62) $display("FAIL texv_edge@220 got %0d want 62", texv_a[220]); else n_pass++;
        n_checks++; if (texv_a[221] !== 6'd63) $display("FAIL texv_edge@221 got %0d want 63", texv_a[221]); else n_pass++;
        n_checks++; if (texv_a[222] !== e222) $display("FAIL texv_edge@222 got %0d want %0d", texv_a[222], e222); else n_pass++;
    endtask

    task automatic test_invalid();
        int f, l, c;
        set_in(1'b0, 1'b0, 200, 0, 0, 0);
        capture_line();
        line_stats(f, l, c);
        n_checks++; if (c != 0) $display("FAIL invalid_count got %0d want 0", c); else n_pass++;
        test_span(200, 220, 419, 200, "after_invalid");
    endtask

    task automatic test_reset_mid();
        int c;
        set_in(1'b1, 1'b1, 200, 12, 16'h0004, 16'h0000);
        tick();
        while (hpos != 10'd300) tick();
        n_checks++; if (o_wall_en !== 1'b1) $display("FAIL mid_wall_pre got %0b want 1", o_wall_en); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (o_wall_en !== 1'b0) $display("FAIL mid_wall_post got %0b want 0", o_wall_en); else n_pass++;
        n_checks++; if (o_side !== 1'b0) $display("FAIL mid_side got %0b want 0", o_side); else n_pass++;
        n_checks++; if (o_texu !== 6'd0) $display("FAIL mid_texu got %0d want 0", o_texu); else n_pass++;
        n_checks++; if (o_texv !== 6'd0) $display("FAIL mid_texv got %0d want 0", o_texv); else n_pass++;
        c = 0;
        while (hpos != 10'd799) begin
            tick();
            if (o_wall_en) c++;
        end
        n_checks++; if (c != 0) $display("FAIL mid_rest_wall got %0d want 0", c); else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        hmax  = 1'b0;
        hpos  = 10'd0;
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        test_reset();
        test_span(200, 220, 419, 200, "size200");
        test_latch();
        test_span(700, 0, 639, 640, "size700");
        test_span(400, 120, 519, 400, "back_to_back400");
        test_span(1, -1, -1, 0, "size1");
        test_span(2, 319, 320, 2, "size2");
        test_texv_step();
        test_texv_edge();
        test_invalid();
        test_reset_mid();
        test_span(200, 220, 419, 200, "after_reset");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
